// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional macro MDU_DIV0_FLAG_EN adds the o_DivZero completion flag.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic                  i_MTHI,
    input  logic                  i_MTLO,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO,
    output logic                  o_Busy,
    output logic                  o_Done
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic                  o_DivZero
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state;
    logic [CW-1:0]   iterCnt;
    logic            isDiv;
    logic            divZero;
    logic            negRes;
    logic            negRem;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [W-1:0]    origA;
    logic [2*W-1:0]  prod;
    logic [W:0]      rem;

    logic            signA;
    logic            signB;
    logic [W-1:0]    absA;
    logic [W-1:0]    absB;
    logic [W:0]      mulSum;
    logic [W:0]      remShift;
    logic [W:0]      remDiff;
    logic            remGe;
    logic [2*W-1:0]  prodFix;
    logic [W-1:0]    quotFix;
    logic [W-1:0]    remFix;
    logic            remTopUnused;

    assign o_Busy = (state != IDLE);

    // The remainder never exceeds the divisor between steps, so its top bit
    // only matters transiently inside the trial subtraction.
    assign remTopUnused = rem[W];

    // Operand conditioning, one shift-add / shift-subtract step, sign fix-up
    always_comb begin
        signA    = ~i_Op[0] & i_SrcA[W-1];
        signB    = ~i_Op[0] & i_SrcB[W-1];
        absA     = signA ? -i_SrcA : i_SrcA;
        absB     = signB ? -i_SrcB : i_SrcB;
        mulSum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opA : {W{1'b0}})};
        remShift = {rem[W-1:0], opA[W-1]};
        remGe    = (remShift >= {1'b0, opB});
        remDiff  = remShift - {1'b0, opB};
        prodFix  = negRes ? -prod : prod;
        quotFix  = negRes ? -opA : opA;
        remFix   = negRem ? -rem[W-1:0] : rem[W-1:0];
    end

    // Control FSM, datapath registers and HI/LO
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state   <= IDLE;
            iterCnt <= '0;
            isDiv   <= 1'b0;
            divZero <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            opA     <= '0;
            opB     <= '0;
            origA   <= '0;
            prod    <= '0;
            rem     <= '0;
            o_HI    <= '0;
            o_LO    <= '0;
            o_Done  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            o_DivZero <= 1'b0;
`endif
        end else begin
            o_Done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            o_DivZero <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (i_Start) begin
                        state   <= CALC;
                        iterCnt <= '0;
                        isDiv   <= i_Op[1];
                        divZero <= i_Op[1] & (i_SrcB == '0);
                        negRes  <= signA ^ signB;
                        negRem  <= signA;
                        opA     <= absA;
                        opB     <= absB;
                        origA   <= i_SrcA;
                        prod    <= {{W{1'b0}}, absB};
                        rem     <= '0;
                    end else begin
                        if (i_MTHI) o_HI <= i_SrcA;
                        if (i_MTLO) o_LO <= i_SrcA;
                    end
                end
                CALC: begin
                    iterCnt <= iterCnt + CW'(1);
                    if (isDiv) begin
                        rem <= remGe ? remDiff : remShift;
                        opA <= {opA[W-2:0], remGe};
                    end else begin
                        prod <= {mulSum, prod[W-1:1]};
                    end
                    if (iterCnt == CW'(W - 1)) state <= FIN;
                end
                FIN: begin
                    state  <= IDLE;
                    o_Done <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
                    o_DivZero <= divZero;
`endif
                    if (divZero) begin
                        o_HI <= origA;
                        o_LO <= '1;
                    end else if (isDiv) begin
                        o_HI <= remFix;
                        o_LO <= quotFix;
                    end else begin
                        o_HI <= prodFix[2*W-1:W];
                        o_LO <= prodFix[W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
// Expected HI/LO are queued at launch and popped at o_Done.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
`ifdef MDU_DIV0_FLAG_EN
    logic         dz;
`endif

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .i_CLK  (clk),
        .i_RST  (rst),
        .i_Start(start),
        .i_Op   (op),
        .i_SrcA (a),
        .i_SrcB (b),
        .i_MTHI (mthi),
        .i_MTLO (mtlo),
        .o_HI   (hi),
        .o_LO   (lo),
        .o_Busy (busy),
        .o_Done (done)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .o_DivZero(dz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edz, input bit moveAtStart,
                         input bit interfere);
        exp_t e;
        logic [W-1:0] prevHi;
        logic [W-1:0] prevLo;
        int n;
        int busyCnt;
        bit seen;
        e = '{hi: eh, lo: el, dz: edz};
        sb.push_back(e);
        prevHi = hi;
        prevLo = lo;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        mthi = moveAtStart;
        mtlo = moveAtStart;
        tick();
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        n = 1;
        busyCnt = 0;
        seen = 0;
        while (n < 3 * W) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busyCnt++;
            if (n == W / 2) begin
                check({tag, "/hiHold"}, hi, prevHi);
                check({tag, "/loHold"}, lo, prevLo);
            end
            if (interfere && n == 5) begin
                start = 1'b1;
                op = 2'b10;
                a = 32'hDEAD_BEEF;
                b = 32'h1;
                mthi = 1'b1;
                mtlo = 1'b1;
            end
            if (interfere && n == 6) begin
                start = 1'b0;
                mthi = 1'b0;
                mtlo = 1'b0;
            end
            tick();
            n++;
        end
        check({tag, "/doneSeen"}, W'(seen), W'(1));
        check({tag, "/latency"}, W'(n), W'(W + 2));
        check({tag, "/busyCycles"}, W'(busyCnt), W'(W + 1));
        check({tag, "/busyAtDone"}, W'(busy), W'(0));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "/hi"}, hi, e.hi);
            check({tag, "/lo"}, lo, e.lo);
`ifdef MDU_DIV0_FLAG_EN
            check({tag, "/divZero"}, W'(dz), W'(e.dz));
`endif
        end
        tick();
        check({tag, "/donePulse"}, W'(done), W'(0));
`ifdef MDU_DIV0_FLAG_EN
        check({tag, "/divZeroPulse"}, W'(dz), W'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneCnt;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        tick();
        tick();
        check("reset/hi", hi, '0);
        check("reset/lo", lo, '0);
        check("reset/busy", W'(busy), W'(0));
        check("reset/done", W'(done), W'(0));
        rst = 1'b0;
        tick();

        runOp("mult", 2'b00, 32'd7, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        runOp("div", 2'b10, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        runOp("divOvf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1'b0, 0, 0);
        runOp("divu0", 2'b11, 32'd100, 32'd0,
              32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0, 0);
        runOp("div0", 2'b10, 32'hFFFF_FFF0, 32'd0,
              32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0, 0);
        runOp("busyIgnore", 2'b01, 32'd3, 32'd5,
              32'h0, 32'd15, 1'b0, 0, 1);

        a = 32'h1234;
        mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        check("mtlo/lo", lo, 32'h1234);
        check("mtlo/hi", hi, 32'h0);
        check("mtlo/done", W'(done), W'(0));

        a = 32'hCAFE;
        mthi = 1'b1;
        mtlo = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mtBoth/hi", hi, 32'hCAFE);
        check("mtBoth/lo", lo, 32'hCAFE);
        check("mtBoth/done", W'(done), W'(0));

        runOp("startWins", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0, 32'h1, 1'b0, 1, 0);
        runOp("divNeg", 2'b10, 32'd100, 32'hFFFF_FFF9,
              32'd2, 32'hFFFF_FFF2, 1'b0, 0, 0);
        runOp("divu", 2'b11, 32'hFFFF_FFFF, 32'h10,
              32'hF, 32'h0FFF_FFFF, 1'b0, 0, 0);

        op = 2'b11;
        a = 32'd1000;
        b = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort/busy", W'(busy), W'(0));
        check("abort/hi", hi, '0);
        check("abort/lo", lo, '0);
        check("abort/done", W'(done), W'(0));
        doneCnt = 0;
        for (int i = 0; i < W + 8; i++) begin
            if (done) doneCnt++;
            tick();
        end
        check("abort/noDone", W'(doneCnt), W'(0));

        runOp("multMin", 2'b00, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0, 1'b0, 0, 0);

        check("scoreboard/empty", W'(sb.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
